// File: rtl/sb_config_loader.sv
// Configuration initiator: decodes a header/data word stream and drives the shared
// config_data bus with one-cycle per-tile write strobes, plus XOR checksum verification.
module sb_config_loader #(
    parameter int num_tiles = 16,
    parameter int width     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     bs_data,
    input  logic                 bs_valid,
    output logic                 bs_ready,
    output logic [width-1:0]     config_data,
    output logic [num_tiles-1:0] config_en,
    output logic [15:0]          config_count,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_HEADER,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  OP_WRITE   = 8'h01;
    localparam logic [7:0]  OP_END     = 8'hFF;
    localparam logic [15:0] ADDR_BCAST = 16'hFFFF;

    state_t               state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic [width-1:0]     data_q, data_d;
    logic [num_tiles-1:0] en_q, en_d;
    logic [15:0]          count_q, count_d;
    logic [width-1:0]     chk_q, chk_d;
    logic                 xfer;

    logic [7:0]  hdr_op;
    logic [7:0]  hdr_rsvd;
    logic [15:0] hdr_addr;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic addr_legal(input logic [15:0] a);
        return (a == ADDR_BCAST) || ({16'h0, a} < 32'(num_tiles));
    endfunction

    assign hdr_op   = bs_data[31:24];
    assign hdr_rsvd = bs_data[23:16];
    assign hdr_addr = bs_data[15:0];

    // Ready is masked by reset so no word is ever offered as accepted during reset.
    assign bs_ready = ~reset & ((state_q == S_HEADER) || (state_q == S_DATA) ||
                                (state_q == S_CHECK));
    assign xfer     = bs_valid & bs_ready;

    assign config_data  = data_q;
    assign config_en    = en_q;
    assign config_count = count_q;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HEADER;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
            count_q <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            count_q <= count_d;
            chk_q   <= chk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = '0;
        count_d = count_q;
        chk_d   = chk_q;
        case (state_q)
            S_HEADER: begin
                if (xfer) begin
                    if (hdr_rsvd != 8'h00) begin
                        state_d = S_ERR;
                    end else if (hdr_op == OP_WRITE && addr_legal(hdr_addr)) begin
                        addr_d  = hdr_addr;
                        state_d = S_DATA;
                    end else if (hdr_op == OP_END) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    data_d = bs_data;
                    for (int i = 0; i < num_tiles; i++) begin
                        en_d[i] = (addr_q == ADDR_BCAST) || (addr_q == 16'(i));
                    end
                    chk_d   = chk_q ^ bs_data;
                    count_d = sat_inc(count_q);
                    state_d = S_HEADER;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (bs_data == chk_q) ? S_DONE : S_ERR;
                end
            end
            default: ;
        endcase
    end

endmodule
